uart_cmd_parser: RTL

Parametrised UART command-frame parser that sits between the UART receiver and the SDRAM write-FIFO/controller trigger logic. It accepts a header byte, a big-endian address, and an optional write payload. It streams payload bytes into the write FIFO and issues single-cycle write or read triggers carrying the decoded address. It adds inter-byte timeout, frame-error reporting and an optional trailing checksum.

---
 rtl/uart_cmd_parser.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: turns a UART byte stream of command frames
// (header, big-endian address, optional write payload) into write-FIFO pushes
// and single-cycle write/read triggers.
// It also applies an inter-byte timeout and reports frame errors.
// Optional feature: define UART_CMD_CHECKSUM_EN to require a trailing XOR
// checksum byte on every frame. With the macro undefined, frames carry no
// checksum byte.
module uart_cmd_parser #(
    parameter int         PAYLOAD_LEN = 4,
    parameter int         ADDR_BYTES  = 3,
    parameter logic [7:0] WR_CMD      = 8'h55,
    parameter logic [7:0] RD_CMD      = 8'hAA,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_done,
    input  logic [7:0]  uart_data,
    output logic        wfifo_wr_en,
    output logic [7:0]  wfifo_data,
    output logic        wr_trig,
    output logic        rd_trig,
    output logic [31:0] cmd_addr,
    output logic        wr_abort,
    output logic        frame_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(PAYLOAD_LEN + 1);
    localparam int TO_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2
`ifdef UART_CMD_CHECKSUM_EN
        , S_CSUM = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              is_wr_q, is_wr_d;
    logic [31:0]       addr_sr_q, addr_sr_d;
    logic [2:0]        addr_cnt_q, addr_cnt_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TO_W-1:0]   gap_q, gap_d;
    logic              wfifo_wr_en_q, wfifo_wr_en_d;
    logic [7:0]        wfifo_data_q, wfifo_data_d;
    logic              wr_trig_q, wr_trig_d;
    logic              rd_trig_q, rd_trig_d;
    logic [31:0]       cmd_addr_q, cmd_addr_d;
    logic              wr_abort_q, wr_abort_d;
    logic              frame_err_q, frame_err_d;
    logic              addr_done_s;
    logic              timeout_s;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Next-state, counter and output-pulse computation for the frame FSM.
    always_comb begin
        state_d       = state_q;
        is_wr_d       = is_wr_q;
        addr_sr_d     = addr_sr_q;
        addr_cnt_d    = addr_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        wfifo_wr_en_d = 1'b0;
        wfifo_data_d  = 8'h00;
        wr_trig_d     = 1'b0;
        rd_trig_d     = 1'b0;
        cmd_addr_d    = cmd_addr_q;
        wr_abort_d    = 1'b0;
        frame_err_d   = 1'b0;
        addr_done_s   = 1'b0;
        timeout_s     = 1'b0;
        gap_d         = '0;
`ifdef UART_CMD_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        // Gap counter runs inside a frame; a byte in the expiry cycle wins.
        if (TIMEOUT_CYC > 0 && state_q != S_IDLE && !rx_done) begin
            gap_d     = gap_q + TO_W'(1);
            timeout_s = (gap_q == TO_W'(TIMEOUT_CYC - 1));
        end else begin
            gap_d     = '0;
            timeout_s = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_done && (uart_data == WR_CMD || uart_data == RD_CMD)) begin
                    is_wr_d    = (uart_data == WR_CMD);
                    addr_sr_d  = 32'h0000_0000;
                    addr_cnt_d = 3'd0;
                    byte_cnt_d = '0;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d     = uart_data;
`endif
                    if (ADDR_BYTES == 0) begin
                        addr_done_s = 1'b1;
                    end else begin
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (rx_done) begin
                    addr_sr_d  = {addr_sr_q[23:0], uart_data};
                    addr_cnt_d = addr_cnt_q + 3'd1;
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d     = csum_q ^ uart_data;
`endif
                    if (addr_cnt_q == 3'(ADDR_BYTES - 1)) begin
                        addr_done_s = 1'b1;
                    end else begin
                        addr_done_s = 1'b0;
                    end
                end else begin
                    addr_done_s = 1'b0;
                end
            end
            S_DATA: begin
                if (rx_done) begin
                    wfifo_wr_en_d = 1'b1;
                    wfifo_data_d  = uart_data;
                    byte_cnt_d    = byte_cnt_q + CNT_W'(1);
`ifdef UART_CMD_CHECKSUM_EN
                    csum_d        = csum_q ^ uart_data;
`endif
                    if (byte_cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
`ifdef UART_CMD_CHECKSUM_EN
                        state_d    = S_CSUM;
`else
                        wr_trig_d  = 1'b1;
                        cmd_addr_d = addr_sr_q;
                        state_d    = S_IDLE;
`endif
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            S_CSUM: begin
                if (rx_done) begin
                    if (uart_data == csum_q) begin
                        wr_trig_d  = is_wr_q;
                        rd_trig_d  = !is_wr_q;
                        cmd_addr_d = addr_sr_q;
                    end else begin
                        frame_err_d = 1'b1;
                        wr_abort_d  = is_wr_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Post-address transition, shared by the header (no address) and ADDR paths.
        if (addr_done_s) begin
            if (is_wr_d) begin
                state_d = S_DATA;
            end else begin
`ifdef UART_CMD_CHECKSUM_EN
                state_d    = S_CSUM;
`else
                rd_trig_d  = 1'b1;
                cmd_addr_d = addr_sr_d;
                state_d    = S_IDLE;
`endif
            end
        end else begin
            addr_done_s = 1'b0;
        end

        // Timeout only fires without rx_done, so it never collides with a trigger.
        if (timeout_s) begin
            frame_err_d = 1'b1;
            wr_abort_d  = is_wr_q && (byte_cnt_q != '0);
            state_d     = S_IDLE;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // State, counters and registered outputs; reset abandons any frame silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            is_wr_q       <= 1'b0;
            addr_sr_q     <= 32'h0000_0000;
            addr_cnt_q    <= 3'd0;
            byte_cnt_q    <= '0;
            gap_q         <= '0;
            wfifo_wr_en_q <= 1'b0;
            wfifo_data_q  <= 8'h00;
            wr_trig_q     <= 1'b0;
            rd_trig_q     <= 1'b0;
            cmd_addr_q    <= 32'h0000_0000;
            wr_abort_q    <= 1'b0;
            frame_err_q   <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q        <= 8'h00;
`endif
        end else begin
            state_q       <= state_d;
            is_wr_q       <= is_wr_d;
            addr_sr_q     <= addr_sr_d;
            addr_cnt_q    <= addr_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            gap_q         <= gap_d;
            wfifo_wr_en_q <= wfifo_wr_en_d;
            wfifo_data_q  <= wfifo_data_d;
            wr_trig_q     <= wr_trig_d;
            rd_trig_q     <= rd_trig_d;
            cmd_addr_q    <= cmd_addr_d;
            wr_abort_q    <= wr_abort_d;
            frame_err_q   <= frame_err_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q        <= csum_d;
`endif
        end
    end

    assign wfifo_wr_en = wfifo_wr_en_q;
    assign wfifo_data  = wfifo_data_q;
    assign wr_trig     = wr_trig_q;
    assign rd_trig     = rd_trig_q;
    assign cmd_addr    = cmd_addr_q;
    assign wr_abort    = wr_abort_q;
    assign frame_err   = frame_err_q;
    assign busy        = (state_q != S_IDLE);

endmodule
